// File: rtl/lsu_txn.sv
// lsu_txn: sequential load/store unit between the core and an XLEN-wide data-memory port.
// Define MISALIGN_TRAP_EN to fault misaligned H/W/D accesses instead of aligning them down.
module lsu_txn #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_store,
  input  logic [2:0]        i_req_funct3,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_resp_valid,
  output logic [XLEN-1:0]   o_resp_data,
  output logic              o_resp_err,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  output logic              o_mem_rstrb,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic              i_mem_ready
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Lane-shifted load data truncated to size and extended; D loads pass through untouched.
  function automatic logic [XLEN-1:0] f_load(input logic [XLEN-1:0] rdata,
                                             input logic [OFF-1:0]  off,
                                             input logic [2:0]      f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] m;
    logic [XLEN-1:0] res;
    logic            s;
    sh = rdata >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   begin m = XLEN'(8'hFF);        s = sh[7];  end
      2'b01:   begin m = XLEN'(16'hFFFF);     s = sh[15]; end
      2'b10:   begin m = XLEN'(32'hFFFF_FFFF); s = sh[31]; end
      default: begin m = {XLEN{1'b1}};        s = 1'b0;   end
    endcase
    res = sh & m;
    if (!f3[2] && s) res = res | ~m;
    else             res = res;
    return res;
  endfunction

  function automatic logic [XLEN-1:0] f_repl(input logic [XLEN-1:0] wdata,
                                             input logic [1:0]      sz);
    logic [XLEN-1:0] res;
    int              idx;
    res = {XLEN{1'b0}};
    for (int k = 0; k < NB; k++) begin
      idx = k & ((1 << sz) - 1);
      res[8*k +: 8] = wdata[8*idx +: 8];
    end
    return res;
  endfunction

  function automatic logic [NB-1:0] f_wstrb(input logic [1:0]     sz,
                                            input logic [OFF-1:0] off);
    logic [NB-1:0] base;
    base = NB'((1 << (1 << sz)) - 1);
    return base << off;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic            r_store;
  logic [2:0]      r_f3;
  logic [OFF-1:0]  r_off;
  logic [TW-1:0]   r_tcnt;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [NB-1:0]   r_mem_wstrb;
  logic            r_mem_rstrb;
  logic [XLEN-1:0] r_resp_data;
  logic            r_resp_err;

  logic [1:0]      w_sz;
  logic [OFF-1:0]  w_lowmask;
  logic [OFF-1:0]  w_off_al;
  logic            w_illegal;
  logic            w_misal;
  logic            w_bad;
  logic            w_accept;
  logic            w_busy;
  logic            w_timeout;

  assign w_sz      = i_req_funct3[1:0];
  assign w_lowmask = OFF'((1 << w_sz) - 1);
  assign w_off_al  = i_req_addr[OFF-1:0] & ~w_lowmask;
  assign w_illegal = (i_req_store && i_req_funct3[2]) || (i_req_funct3 == 3'b111) ||
                     ((XLEN == 32) && ((w_sz == 2'b11) || (i_req_funct3 == 3'b110)));
`ifdef MISALIGN_TRAP_EN
  assign w_misal   = (i_req_addr[OFF-1:0] & w_lowmask) != {OFF{1'b0}};
`else
  assign w_misal   = 1'b0;
`endif
  assign w_bad     = w_illegal || w_misal;
  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_busy    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  // mem_ready beats the timeout when both land in the same cycle
  assign w_timeout = (TIMEOUT_CYCLES > 0) && w_busy && !i_mem_ready && (r_tcnt == TLIM);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_bad ? S_RESP : S_ISSUE;
        else          w_next = S_IDLE;
      end
      S_ISSUE, S_WAIT: begin
        if (i_mem_ready || w_timeout) w_next = S_RESP;
        else                          w_next = S_WAIT;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, bus drive, load return and timeout counting
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_store     <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= {OFF{1'b0}};
      r_tcnt      <= {TW{1'b0}};
      r_mem_addr  <= {XLEN{1'b0}};
      r_mem_wdata <= {XLEN{1'b0}};
      r_mem_wstrb <= {NB{1'b0}};
      r_mem_rstrb <= 1'b0;
      r_resp_data <= {XLEN{1'b0}};
      r_resp_err  <= 1'b0;
    end else begin
      // ISSUE always lasts exactly one cycle, so the read strobe is a one-shot
      r_mem_rstrb <= w_accept && !w_bad && !i_req_store;
      if (w_accept) begin
        r_store     <= i_req_store;
        r_f3        <= i_req_funct3;
        r_off       <= w_off_al;
        r_tcnt      <= {TW{1'b0}};
        r_resp_data <= {XLEN{1'b0}};
        r_resp_err  <= w_bad;
        if (!w_bad) begin
          r_mem_addr  <= {i_req_addr[XLEN-1:OFF], {OFF{1'b0}}};
          r_mem_wdata <= f_repl(i_req_wdata, w_sz);
          r_mem_wstrb <= i_req_store ? f_wstrb(w_sz, w_off_al) : {NB{1'b0}};
        end
      end else if (w_busy) begin
        if (i_mem_ready) begin
          r_mem_wstrb <= {NB{1'b0}};
          r_resp_err  <= 1'b0;
          r_resp_data <= r_store ? {XLEN{1'b0}} : f_load(i_mem_rdata, r_off, r_f3);
        end else if (w_timeout) begin
          r_mem_wstrb <= {NB{1'b0}};
          r_resp_err  <= 1'b1;
          r_resp_data <= {XLEN{1'b0}};
        end else if (TIMEOUT_CYCLES > 0) begin
          r_tcnt <= r_tcnt + {{(TW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_wstrb  = r_mem_wstrb;
  assign o_mem_rstrb  = r_mem_rstrb;

endmodule

// File: tb/tb_lsu_txn.sv
// Bench for lsu_txn: a 32-bit unit with a 4-cycle timeout and a 64-bit unit without one.
module tb_lsu_txn;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store, req_ready;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata, resp_data, mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, mem_rstrb, mem_ready;
  logic [3:0]  mem_wstrb;

  logic        d_req_valid, d_req_store, d_req_ready;
  logic [2:0]  d_req_f3;
  logic [63:0] d_req_addr, d_req_wdata, d_resp_data, d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic        d_resp_valid, d_resp_err, d_mem_rstrb, d_mem_ready;
  logic [7:0]  d_mem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] q32[$];
  logic [64:0] q64[$];

  always #5 clk = ~clk;

  lsu_txn #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_store(req_store), .i_req_funct3(req_f3), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
    .o_resp_err(resp_err), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wstrb(mem_wstrb), .o_mem_rstrb(mem_rstrb), .i_mem_rdata(mem_rdata),
    .i_mem_ready(mem_ready));

  lsu_txn #(.XLEN(64), .TIMEOUT_CYCLES(0)) u_dut64 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(d_req_valid), .o_req_ready(d_req_ready),
    .i_req_store(d_req_store), .i_req_funct3(d_req_f3), .i_req_addr(d_req_addr),
    .i_req_wdata(d_req_wdata), .o_resp_valid(d_resp_valid), .o_resp_data(d_resp_data),
    .o_resp_err(d_resp_err), .o_mem_addr(d_mem_addr), .o_mem_wdata(d_mem_wdata),
    .o_mem_wstrb(d_mem_wstrb), .o_mem_rstrb(d_mem_rstrb), .i_mem_rdata(d_mem_rdata),
    .i_mem_ready(d_mem_ready));

  // Response scoreboards: every resp_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    logic [32:0] e32;
    logic [64:0] e64;
    if (resp_valid === 1'b1) begin
      n_cmp++;
      if (q32.size() == 0) begin
        n_bad++;
        $display("FAIL resp32_unexpected: got data=%h err=%b, expected no response", resp_data, resp_err);
      end else begin
        e32 = q32.pop_front();
        if ({resp_data, resp_err} !== e32) begin
          n_bad++;
          $display("FAIL resp32: got data=%h err=%b, expected data=%h err=%b",
                   resp_data, resp_err, e32[32:1], e32[0]);
        end
      end
    end
    if (d_resp_valid === 1'b1) begin
      n_cmp++;
      if (q64.size() == 0) begin
        n_bad++;
        $display("FAIL resp64_unexpected: got data=%h err=%b, expected no response", d_resp_data, d_resp_err);
      end else begin
        e64 = q64.pop_front();
        if ({d_resp_data, d_resp_err} !== e64) begin
          n_bad++;
          $display("FAIL resp64: got data=%h err=%b, expected data=%h err=%b",
                   d_resp_data, d_resp_err, e64[64:1], e64[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // One 32-bit transaction; mem_ready rises lat cycles after ISSUE (lat >= TMO never answers)
  task automatic txn32(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int lat,
                       input logic bad, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_wstrb, input logic [31:0] exp_data, input logic exp_err);
    int guard;
    int rc;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wait: req_ready=%b, expected 1 within 20 cycles", req_ready);
    end
    req_valid = 1'b1; req_store = st; req_f3 = f3; req_addr = addr; req_wdata = wdata;
    mem_rdata = rdata;
    q32.push_back({exp_data, exp_err});
    rc = bad ? 1 : ((lat < TMO) ? lat + 2 : TMO + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c < rc; c++) begin
      mem_ready = (c - 1 == lat);
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0 || mem_addr !== exp_addr || mem_wstrb !== exp_wstrb ||
          mem_rstrb !== (c == 1 && !st) || (st && mem_wdata !== exp_wdata)) begin
        n_bad++;
        $display("FAIL bus_cycle%0d: got rv=%b addr=%h wstrb=%b rstrb=%b wdata=%h, expected rv=0 addr=%h wstrb=%b rstrb=%b wdata=%h",
                 c, resp_valid, mem_addr, mem_wstrb, mem_rstrb, mem_wdata,
                 exp_addr, exp_wstrb, (c == 1 && !st), exp_wdata);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b1 || mem_wstrb !== 4'b0000 || mem_rstrb !== 1'b0) begin
      n_bad++;
      $display("FAIL resp_cycle%0d: got rv=%b wstrb=%b rstrb=%b, expected rv=1 wstrb=0000 rstrb=0",
               rc, resp_valid, mem_wstrb, mem_rstrb);
    end
    @(posedge clk); #1;
  endtask

  // One 64-bit transaction with mem_ready answered in the ISSUE cycle
  task automatic txn64(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rdata, input logic bad,
                       input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                       input logic [7:0] exp_wstrb, input logic [63:0] exp_data, input logic exp_err);
    d_req_valid = 1'b1; d_req_store = st; d_req_f3 = f3; d_req_addr = addr; d_req_wdata = wdata;
    d_mem_rdata = rdata;
    q64.push_back({exp_data, exp_err});
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    d_mem_ready = !bad;
    @(negedge clk);
    n_cmp++;
    if (bad) begin
      if (d_resp_valid !== 1'b1 || d_mem_rstrb !== 1'b0 || d_mem_wstrb !== 8'h00) begin
        n_bad++;
        $display("FAIL illegal64: got rv=%b rstrb=%b wstrb=%h, expected rv=1 rstrb=0 wstrb=00",
                 d_resp_valid, d_mem_rstrb, d_mem_wstrb);
      end
    end else if (d_resp_valid !== 1'b0 || d_mem_addr !== exp_addr || d_mem_wstrb !== exp_wstrb ||
                 d_mem_rstrb !== !st || (st && d_mem_wdata !== exp_wdata)) begin
      n_bad++;
      $display("FAIL bus64: got rv=%b addr=%h wstrb=%h rstrb=%b wdata=%h, expected rv=0 addr=%h wstrb=%h rstrb=%b wdata=%h",
               d_resp_valid, d_mem_addr, d_mem_wstrb, d_mem_rstrb, d_mem_wdata,
               exp_addr, exp_wstrb, !st, exp_wdata);
    end
    @(posedge clk); #1;
    d_mem_ready = 1'b0;
    if (!bad) begin
      @(negedge clk);
      n_cmp++;
      if (d_resp_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL resp64_cycle2: got rv=%b, expected 1", d_resp_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_f3 = 3'b000; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    d_req_valid = 1'b0; d_req_store = 1'b0; d_req_f3 = 3'b000; d_req_addr = '0; d_req_wdata = '0;
    d_mem_rdata = '0; d_mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, mem_rstrb, mem_wstrb} !== 8'b1000_0000 ||
        resp_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        d_req_ready !== 1'b1 || d_resp_valid !== 1'b0 || d_mem_wstrb !== 8'h00) begin
      n_bad++;
      $display("FAIL reset: got ready=%b rv=%b err=%b rstrb=%b wstrb=%b data=%h addr=%h, expected ready=1 and all else 0",
               req_ready, resp_valid, resp_err, mem_rstrb, mem_wstrb, resp_data, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_loads();
    txn32(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0, 32'h100, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b0);
    txn32(1'b0, 3'b100, 32'h101, 32'h0, 32'h80FF_1234, 1, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0000_0012, 1'b0);
    txn32(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 2, 1'b0, 32'h100, 32'h0, 4'b0000, 32'hFFFF_80FF, 1'b0);
    txn32(1'b0, 3'b010, 32'h208, 32'h0, 32'h8123_4567, 0, 1'b0, 32'h208, 32'h0, 4'b0000, 32'h8123_4567, 1'b0);
  endtask

  task automatic test_stores();
    txn32(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0, 1'b0, 32'h100, 32'hABCD_ABCD, 4'b1100, 32'h0, 1'b0);
    txn32(1'b1, 3'b000, 32'h101, 32'h0000_005A, 32'h0, 0, 1'b0, 32'h100, 32'h5A5A_5A5A, 4'b0010, 32'h0, 1'b0);
    txn32(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 32'h104, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
  endtask

  task automatic test_illegal();
    txn32(1'b1, 3'b100, 32'h40, 32'h1, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    txn32(1'b0, 3'b111, 32'h40, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    txn32(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    txn32(1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    txn32(1'b0, 3'b010, 32'h102, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    txn32(1'b0, 3'b101, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
`else
    txn32(1'b0, 3'b010, 32'h102, 32'h0, 32'h1234_5678, 0, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h1234_5678, 1'b0);
    txn32(1'b0, 3'b101, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0000_80FF, 1'b0);
`endif
  endtask

  task automatic test_timeout();
    txn32(1'b0, 3'b010, 32'h300, 32'h0, 32'h5555_AAAA, 99, 1'b0, 32'h300, 32'h0, 4'b0000, 32'h0, 1'b1);
    txn32(1'b0, 3'b010, 32'h300, 32'h0, 32'h5555_AAAA, TMO - 1, 1'b0, 32'h300, 32'h0, 4'b0000, 32'h5555_AAAA, 1'b0);
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0 || mem_rstrb !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_ready_ignored: got rv=%b rstrb=%b, expected 0 0", resp_valid, mem_rstrb);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_store = 1'b1; req_f3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h11;
    q32.push_back({32'h0, 1'b0});
    q32.push_back({32'h0, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL resp_no_accept: got ready=%b rv=%b, expected ready=0 rv=1", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_after_resp: got ready=%b rv=%b, expected ready=1 rv=0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_wstrb !== 4'b0001 || mem_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL second_issue: got wstrb=%b addr=%h, expected wstrb=0001 addr=00000010", mem_wstrb, mem_addr);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_store = 1'b0; req_f3 = 3'b010; req_addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, mem_rstrb, mem_wstrb} !== 8'b1000_0000 ||
        mem_addr !== 32'h0 || resp_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_in_wait: got ready=%b rv=%b err=%b rstrb=%b wstrb=%b addr=%h, expected ready=1 and all else 0",
               req_ready, resp_valid, resp_err, mem_rstrb, mem_wstrb, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    txn32(1'b1, 3'b100, 32'h44, 32'h7, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
  endtask

  task automatic test_xlen64();
    txn64(1'b0, 3'b110, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 64'h0, 64'h0, 8'h00,
          64'h0000_0000_8765_4321, 1'b0);
    txn64(1'b0, 3'b010, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 64'h0, 64'h0, 8'h00,
          64'hFFFF_FFFF_8765_4321, 1'b0);
    txn64(1'b0, 3'b011, 64'h8, 64'h0, 64'h8000_0000_0000_0001, 1'b0, 64'h8, 64'h0, 8'h00,
          64'h8000_0000_0000_0001, 1'b0);
    txn64(1'b1, 3'b010, 64'h4, 64'h1111_1111_DEAD_BEEF, 64'h0, 1'b0, 64'h0,
          64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 64'h0, 1'b0);
    txn64(1'b0, 3'b111, 64'h10, 64'h0, 64'h0, 1'b1, 64'h0, 64'h0, 8'h00, 64'h0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    test_xlen64();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q32.size() != 0 || q64.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending responses, expected 0/0", q32.size(), q64.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
